// File: rtl/mmult_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : mmult_result_streamer
// Description : Captures the DIMxDIM result matrix on a rising mat_valid and
//               streams it as uppercase ASCII hex rows over a byte handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mmult_result_streamer #(
    parameter int DIM = 3,
    parameter int EW  = 17
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mat_valid,
    input  logic [DIM*DIM*EW-1:0] C_mat,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int HD  = (EW + 3) / 4;
    localparam int NB  = DIM * DIM * EW;
    localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW  = HD * 4;
    localparam int PIW = $clog2(PW);
    localparam int CW  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int DW  = (HD > 1) ? $clog2(HD) : 1;

    localparam logic [CW-1:0] C_LAST  = CW'(DIM - 1);
    localparam logic [DW-1:0] C_DLAST = DW'(HD - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] PH_DIG = 2'd0;
    localparam logic [1:0] PH_SEP = 2'd1;
    localparam logic [1:0] PH_CR  = 2'd2;
    localparam logic [1:0] PH_LF  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [DW-1:0] dig_q, dig_d;
    logic [NB-1:0] cap_q, cap_d;
    logic          mat_valid_q;

    logic          w_start;
    logic          w_xfer;
    logic [IW-1:0] w_base;
    logic [PIW-1:0] w_nsel;
    logic [EW-1:0] w_entry;
    logic [PW-1:0] w_pad;
    logic [3:0]    w_nib;
    logic [7:0]    w_hex;
    logic [7:0]    w_char;

    assign w_start = mat_valid & ~mat_valid_q;
    assign w_xfer  = (state_q == S_EMIT) & tx_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_DIG;
            row_q       <= '0;
            col_q       <= '0;
            dig_q       <= '0;
            cap_q       <= '0;
            mat_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dig_q       <= dig_d;
            cap_q       <= cap_d;
            mat_valid_q <= mat_valid;
        end
    end

    // Current character from the captured entry, MS nibble first, zero-padded
    always_comb begin
        w_base  = IW'((int'(row_q) * DIM + int'(col_q)) * EW);
        w_entry = cap_q[w_base +: EW];
        w_pad   = '0;
        w_pad[EW-1:0] = w_entry;
        w_nsel  = PIW'((HD - 1 - int'(dig_q)) * 4);
        w_nib   = w_pad[w_nsel +: 4];
        w_hex   = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
        case (phase_q)
            PH_DIG:  w_char = w_hex;
            PH_SEP:  w_char = 8'h20;
            PH_CR:   w_char = 8'h0D;
            default: w_char = 8'h0A;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        row_d   = row_q;
        col_d   = col_q;
        dig_d   = dig_q;
        cap_d   = cap_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    cap_d   = C_mat;
                    phase_d = PH_DIG;
                    row_d   = '0;
                    col_d   = '0;
                    dig_d   = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_xfer) begin
                    case (phase_q)
                        PH_DIG: begin
                            if (dig_q == C_DLAST) begin
                                dig_d   = '0;
                                phase_d = (col_q == C_LAST) ? PH_CR : PH_SEP;
                            end else begin
                                dig_d = dig_q + 1'b1;
                            end
                        end
                        PH_SEP: begin
                            col_d   = col_q + 1'b1;
                            phase_d = PH_DIG;
                        end
                        PH_CR: phase_d = PH_LF;
                        default: begin
                            col_d   = '0;
                            phase_d = PH_DIG;
                            if (row_q == C_LAST) begin
                                state_d = S_DONE;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state_q == S_EMIT);
        tx_data  = (state_q == S_EMIT) ? w_char : 8'h00;
        busy     = (state_q == S_EMIT);
        done     = (state_q == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_mmult_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmult_result_streamer
// Description : Directed self-checking bench for mmult_result_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmult_result_streamer;

    localparam int DIM = 3;
    localparam int EW  = 17;
    localparam int FRAME = 57;

    logic                  clk;
    logic                  reset_n;
    logic                  mat_valid;
    logic [DIM*DIM*EW-1:0] C_mat;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;
    logic                  done;

    mmult_result_streamer #(.DIM(DIM), .EW(EW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mat_valid (mat_valid),
        .C_mat     (C_mat),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] rx [0:63];
    int nb, ndone, done_at, first_at, stall_bad, busy_first;

    string exp0 = {"00000 00000 00000\r\n", "00000 00000 00000\r\n", "00000 00000 00000\r\n"};
    string exp2 = {"1FFFF 00001 00001\r\n", "00001 00001 00001\r\n", "00001 00001 00ABC\r\n"};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load_case2();
        C_mat = '0;
        for (int k = 0; k < DIM*DIM; k++) C_mat[k*EW +: EW] = 17'h00001;
        C_mat[0 +: EW]    = 17'h1FFFF;
        C_mat[8*EW +: EW] = 17'h00ABC;
    endtask

    // Sink model: each negedge picks tx_ready and logs the byte that the next posedge accepts
    task automatic run_frame(input bit rnd, input int drop_at, input int rerise_at,
                             input bit corrupt, input int max_cyc);
        logic [7:0] prev_data;
        bit prev_stall;
        nb = 0; ndone = 0; done_at = -1; first_at = -1; stall_bad = 0; busy_first = 0;
        prev_stall = 0; prev_data = 8'h00;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (i == drop_at)   mat_valid = 1'b0;
            if (i == rerise_at) mat_valid = 1'b1;
            if (corrupt && i == 3) C_mat = ~C_mat;
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (i == 1) busy_first = int'(busy);
            if (prev_stall && tx_valid && (tx_data !== prev_data)) stall_bad++;
            if (tx_valid && tx_ready) begin
                if (nb < 64) rx[nb] = tx_data;
                if (first_at < 0) first_at = i;
                nb++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
        end
    endtask

    task automatic check_stream(input string tag, input string expv);
        chk({tag, "_count"}, nb, FRAME);
        for (int k = 0; k < FRAME && k < nb; k++)
            chk($sformatf("%s_byte%0d", tag, k), {24'h0, rx[k]}, {24'h0, expv[k]});
    endtask

    initial begin
        reset_n = 1'b0; mat_valid = 1'b0; tx_ready = 1'b0; C_mat = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_tx_valid", {31'h0, tx_valid}, 0);
        chk("rst_tx_data",  {24'h0, tx_data}, 0);
        chk("rst_busy",     {31'h0, busy}, 0);
        chk("rst_done",     {31'h0, done}, 0);

        // 1: zero matrix, ready always high, exact latency
        C_mat = '0; mat_valid = 1'b1;
        run_frame(0, 1, 0, 0, 65);
        check_stream("t1", exp0);
        chk("t1_first_at", first_at, 1);
        chk("t1_busy_first", busy_first, 1);
        chk("t1_done_at", done_at, 58);
        chk("t1_ndone", ndone, 1);
        chk("t1_idle_valid", {31'h0, tx_valid}, 0);

        // 2: mixed entries; C_mat disturbed after capture
        load_case2(); mat_valid = 1'b1;
        run_frame(0, 1, 0, 1, 65);
        check_stream("t2", exp2);
        chk("t2_ndone", ndone, 1);

        // 3: random backpressure
        load_case2(); mat_valid = 1'b1;
        run_frame(1, 1, 0, 0, 400);
        check_stream("t3", exp2);
        chk("t3_stall_stable", stall_bad, 0);
        chk("t3_ndone", ndone, 1);

        // 4: level-held mat_valid starts exactly one frame
        C_mat = '0; mat_valid = 1'b1;
        run_frame(0, 200, 0, 0, 230);
        chk("t4_count", nb, FRAME);
        chk("t4_ndone", ndone, 1);

        // 5: reset mid-frame after byte 20, then restart
        load_case2(); mat_valid = 1'b1;
        run_frame(0, 1, 0, 0, 20);
        chk("t5_partial", nb, 20);
        @(negedge clk);
        tx_ready = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t5_rst_valid", {31'h0, tx_valid}, 0);
        chk("t5_rst_busy",  {31'h0, busy}, 0);
        run_frame(0, 0, 0, 0, 20);
        chk("t5_no_bytes", nb, 0);
        C_mat = '0; mat_valid = 1'b1;
        run_frame(0, 1, 0, 0, 65);
        check_stream("t5_restart", exp0);

        // 6: second rise during a frame is ignored
        load_case2(); mat_valid = 1'b1;
        run_frame(0, 2, 10, 0, 130);
        mat_valid = 1'b0;
        check_stream("t6", exp2);
        chk("t6_ndone", ndone, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
